// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, defaults and data width.
// UART_TX_PARITY_EN widens the state to 3 bits and adds a PARITY state.
package uart_pkg;

   localparam int UART_CLOCK_FREQ = 50_000_000;
   localparam int UART_BAUD_RATE  = 9600;
   localparam int DATA_BITS       = 8;
   localparam int BIT_W           = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
   localparam int STATE_W = 3;
`else
   localparam int STATE_W = 2;
`endif

   localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(0);
   localparam logic [STATE_W-1:0] S_START = STATE_W'(1);
   localparam logic [STATE_W-1:0] S_DATA  = STATE_W'(2);
   localparam logic [STATE_W-1:0] S_STOP  = STATE_W'(3);
`ifdef UART_TX_PARITY_EN
   localparam logic [STATE_W-1:0] S_PARITY = STATE_W'(4);

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit timer: bit_end pulses every BAUD_COUNT enabled clocks.
// Clearing aligns the first bit to frame start.
module uart_baud_gen #(
   parameter int BAUD_COUNT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);

   localparam int CNT_W = $clog2(BAUD_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_end = enable && !clear && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and registered tx line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = UART_CLOCK_FREQ,
   parameter int BAUD_RATE  = UART_BAUD_RATE,
   parameter int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic [STATE_W-1:0]   state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 accept;
   logic                 bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   assign tx_ready = (state_q == S_IDLE);
   assign tx_busy  = !tx_ready;
   assign tx       = tx_q;
   assign tx_done  = done_q;
   assign accept   = tx_ready && tx_valid;

   uart_baud_gen #(
      .BAUD_COUNT(BAUD_COUNT)
   ) u_baud (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (accept),
      .enable (tx_busy),
      .bit_end(bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               state_d   = S_START;
               shift_d   = tx_data;
               bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
               par_d     = even_parity(tx_data);
`endif
            end
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level follows the next state so tx is a clean flop output.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with BAUD_COUNT = 16.
// Honours UART_TX_PARITY_EN for the 11-bit frame tests.
module tb_uart_tx;

   localparam int BC = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx #(
      .BAUD_COUNT(BC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Call right after the negedge at which the byte was presented with
   // tx_ready high; samples every clock of the frame plus the done cycle.
   task automatic watch_frame(input string tag, input logic [7:0] d,
                              input logic p, input logic v0,
                              input logic [7:0] d0, input int inj_at,
                              input logic [7:0] inj_d, input logic inj_hold);
      logic [10:0] pat;
      int err [11];
      int busy_n = 0;
      int done_n = 0;
`ifdef UART_TX_PARITY_EN
      pat = {1'b1, p, d, 1'b0};
`else
      pat = {1'b0, 1'b1, d, 1'b0};
`endif
      foreach (err[i]) err[i] = 0;
      for (int k = 0; k < NB * BC; k++) begin
         @(negedge clk);
         if (tx !== pat[k / BC]) err[k / BC]++;
         if (tx_busy === 1'b1) busy_n++;
         if (tx_done !== 1'b0) done_n++;
         if (k == 0) begin
            tx_valid = v0;
            tx_data  = d0;
         end
         if (inj_at >= 0 && k == inj_at) begin
            tx_valid = 1'b1;
            tx_data  = inj_d;
         end else if (inj_at >= 0 && k == inj_at + 1 && !inj_hold) begin
            tx_valid = 1'b0;
         end
      end
      for (int b = 0; b < NB; b++)
         check($sformatf("%s_bit%0d_errs", tag, b), err[b], 0);
      check({tag, "_busy_clks"}, busy_n, NB * BC);
      check({tag, "_early_done"}, done_n, 0);
      @(negedge clk);
      check({tag, "_done"}, tx_done, 1);
      check({tag, "_ready"}, tx_ready, 1);
      check({tag, "_idle_tx"}, tx, 1);
      check({tag, "_idle_busy"}, tx_busy, 0);
   endtask

   initial begin
      int bad_tx, bad_rdy, n_busy, n_done;

      #2 reset_n = 1'b0;
      #1;
      check("rst_tx", tx, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      bad_tx = 0; bad_rdy = 0; n_busy = 0; n_done = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tx !== 1'b1) bad_tx++;
         if (tx_ready !== 1'b1) bad_rdy++;
         if (tx_busy !== 1'b0) n_busy++;
         if (tx_done !== 1'b0) n_done++;
      end
      check("idle_tx", bad_tx, 0);
      check("idle_ready", bad_rdy, 0);
      check("idle_busy", n_busy, 0);
      check("idle_done", n_done, 0);

      tx_data = 8'hA5; tx_valid = 1'b1;
      watch_frame("a5", 8'hA5, 1'b0, 1'b0, 8'hA5, -1, 8'h00, 1'b0);

      tx_data = 8'h00; tx_valid = 1'b1;
      watch_frame("b2b_00", 8'h00, 1'b0, 1'b1, 8'hFF, -1, 8'h00, 1'b0);
      watch_frame("b2b_ff", 8'hFF, 1'b0, 1'b0, 8'hFF, -1, 8'h00, 1'b0);

      tx_data = 8'h81; tx_valid = 1'b1;
      watch_frame("p81", 8'h81, 1'b0, 1'b0, 8'h81, 40, 8'h3C, 1'b0);
      @(negedge clk);
      check("pulse_lost_busy", tx_busy, 0);
      check("pulse_lost_tx", tx, 1);

      tx_data = 8'h81; tx_valid = 1'b1;
      watch_frame("h81", 8'h81, 1'b0, 1'b0, 8'h81, 40, 8'h3C, 1'b1);
      watch_frame("h3c", 8'h3C, 1'b0, 1'b0, 8'h3C, -1, 8'h00, 1'b0);

      tx_data = 8'h55; tx_valid = 1'b1;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (k == 0) tx_valid = 1'b0;
      end
      check("r55_pre_tx", tx, 0);
      reset_n = 1'b0;
      #1;
      check("r55_async_tx", tx, 1);
      check("r55_async_busy", tx_busy, 0);
      n_done = 0; bad_tx = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 2) reset_n = 1'b1;
         if (tx_done !== 1'b0) n_done++;
         if (tx !== 1'b1) bad_tx++;
      end
      check("r55_no_done", n_done, 0);
      check("r55_tx_high", bad_tx, 0);
      check("r55_ready", tx_ready, 1);

      tx_data = 8'h0F; tx_valid = 1'b1;
      watch_frame("f0f", 8'h0F, 1'b0, 1'b0, 8'h0F, -1, 8'h00, 1'b0);

`ifdef UART_TX_PARITY_EN
      tx_data = 8'h07; tx_valid = 1'b1;
      watch_frame("par07", 8'h07, 1'b1, 1'b0, 8'h07, -1, 8'h00, 1'b0);
      tx_data = 8'h03; tx_valid = 1'b1;
      watch_frame("par03", 8'h03, 1'b0, 1'b0, 8'h03, -1, 8'h00, 1'b0);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
